// File: rtl/param_rr_arbiter.sv
// param_rr_arbiter: N-way registered fixed-priority / round-robin arbiter with hold-time limit.
// Optional grant_id output enabled by defining ARB_GRANT_ID_EN.
module param_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         rr_mode,
    output logic [N-1:0] grant,
    output logic         grant_valid
`ifdef ARB_GRANT_ID_EN
    ,
    output logic [$clog2(N)-1:0] grant_id
`endif
);
    localparam int PW = $clog2(N);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state;
    logic [PW-1:0] rr_ptr, win_idx;
    logic [HW-1:0] hold_cnt;
    logic [N-1:0]  cand, win_oh;
    logic          others, owner_req, hold_hit, found, arb;
    int            j;
    always_comb begin
        others    = |(req & ~grant);
        owner_req = |(req & grant);
        hold_hit  = (MAX_HOLD != 0) && (hold_cnt == HMAX);
        arb       = (state == IDLE) || !owner_req || (hold_hit && others);
        // forced hand-over excludes the current owner from the search
        cand      = (state == GRANT && owner_req && hold_hit) ? (req & ~grant) : req;
        win_idx   = '0;
        found     = 1'b0;
        win_oh    = '0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = rr_mode ? (int'(rr_ptr) + i) % N : i;
            if (!found && cand[j]) begin
                found      = 1'b1;
                win_idx    = PW'(j);
                win_oh[j]  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
            rr_ptr      <= '0;
`ifdef ARB_GRANT_ID_EN
            grant_id    <= '0;
`endif
        end else if (arb) begin
            state       <= found ? GRANT : IDLE;
            grant       <= win_oh;
            grant_valid <= found;
            hold_cnt    <= found ? HW'(1) : '0;
            if (found) rr_ptr <= (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
`ifdef ARB_GRANT_ID_EN
            grant_id    <= found ? win_idx : '0;
`endif
        end else begin
            hold_cnt <= (MAX_HOLD == 0 || hold_hit) ? hold_cnt : hold_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_param_rr_arbiter.sv
// tb_param_rr_arbiter: vector table, hand sequences and randomized model check for param_rr_arbiter.
module tb_param_rr_arbiter;
    localparam int N = 4;
    localparam int MAX_HOLD = 4;
    logic         clk, rst, rr_mode, grant_valid;
    logic [N-1:0] req, grant;
`ifdef ARB_GRANT_ID_EN
    logic [$clog2(N)-1:0] grant_id;
`endif
    int passed = 0, total = 0;
    int m_owner = -1, m_hold = 0, m_ptr = 0;

    param_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode),
        .grant(grant), .grant_valid(grant_valid)
`ifdef ARB_GRANT_ID_EN
        , .grant_id(grant_id)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         r;
        logic [N-1:0] q;
        logic         m;
        logic [N-1:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input logic rr, input int ptr, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = rr ? (ptr + k) % N : k;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic start_owner(input int w);
        m_owner = w;
        m_hold  = (w >= 0) ? 1 : 0;
        if (w >= 0) m_ptr = (w + 1) % N;
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] q, input logic m);
        if (r) begin
            m_owner = -1; m_hold = 0; m_ptr = 0;
        end else if (m_owner < 0 || !q[m_owner]) begin
            start_owner(pick(q, m, m_ptr, -1));
        end else if (MAX_HOLD != 0 && m_hold >= MAX_HOLD && pick(q, m, m_ptr, m_owner) >= 0) begin
            start_owner(pick(q, m, m_ptr, m_owner));
        end else if (MAX_HOLD != 0 && m_hold < MAX_HOLD) begin
            m_hold++;
        end
    endtask

    task automatic apply(input logic r, input logic [N-1:0] q, input logic m);
        rst = r; req = q; rr_mode = m;
        @(posedge clk);
        #1;
        model_step(r, q, m);
    endtask

    task automatic check_out(input string name, input logic [N-1:0] exp);
        check({name, ".grant"}, int'(grant), int'(exp));
        check({name, ".valid"}, int'(grant_valid), int'(|exp));
`ifdef ARB_GRANT_ID_EN
        check({name, ".id"}, int'(grant_id), onehot_idx(exp));
`endif
    endtask

    task automatic add(input logic r, input logic [N-1:0] q, input logic m, input logic [N-1:0] e, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{r: r, q: q, m: m, exp: e});
    endtask

    initial begin
        rst = 1'b1; req = '0; rr_mode = 1'b0;
        // reset holds grant low despite requests; first grant one edge after release
        add(1, 4'b1111, 0, 4'b0000, 2);
        add(0, 4'b1111, 0, 4'b0001, 1);
        // fixed priority, hand-over without bubble
        add(1, 4'b0000, 0, 4'b0000, 1);
        add(0, 4'b1010, 0, 4'b0010, 1);
        add(0, 4'b1000, 0, 4'b1000, 1);
        add(0, 4'b0000, 0, 4'b0000, 1);
        // round robin rotation with hold limit and wrap
        add(1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b1111, 1, 4'b0001, 4);
        add(0, 4'b1111, 1, 4'b0010, 4);
        add(0, 4'b1111, 1, 4'b0100, 4);
        add(0, 4'b1111, 1, 4'b1000, 4);
        add(0, 4'b1111, 1, 4'b0001, 1);
        // lone requester keeps grant beyond the limit
        add(1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b0001, 1, 4'b0001, 10);
        add(0, 4'b0000, 1, 4'b0000, 1);
        // reset mid-grant restores rr pointer to 0
        add(1, 4'b0000, 1, 4'b0000, 1);
        add(0, 4'b1111, 1, 4'b0001, 4);
        add(0, 4'b1111, 1, 4'b0010, 4);
        add(0, 4'b1111, 1, 4'b0100, 1);
        add(1, 4'b1111, 1, 4'b0000, 1);
        add(0, 4'b1111, 1, 4'b0001, 1);
        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].q, vecs[i].m);
            check_out($sformatf("vec%0d", i), vecs[i].exp);
        end

        // fixed mode forced hand-over excludes owner, then lowest index wins again
        apply(1, 4'b0000, 0);
        check_out("fx.rst", 4'b0000);
        for (int i = 0; i < 4; i++) begin
            apply(0, 4'b1111, 0);
            check_out("fx.own0", 4'b0001);
        end
        for (int i = 0; i < 4; i++) begin
            apply(0, 4'b1111, 0);
            check_out("fx.own1", 4'b0010);
        end
        apply(0, 4'b1111, 0);
        check_out("fx.back0", 4'b0001);

        // mode change mid-grant keeps owner; early drop hands over immediately
        apply(1, 4'b0000, 0);
        apply(0, 4'b0101, 0);
        check_out("mc.own0", 4'b0001);
        apply(0, 4'b0101, 1);
        check_out("mc.keep", 4'b0001);
        apply(0, 4'b0100, 1);
        check_out("mc.drop", 4'b0100);

        // randomized run against the reference model
        apply(1, '0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic r, m;
            logic [N-1:0] q, e;
            r = ($urandom_range(99) == 0);
            m = ($urandom_range(7) == 0) ? ~rr_mode : rr_mode;
            q = ($urandom_range(3) == 0) ? req ^ N'($urandom) : req;
            apply(r, q, m);
            e = (m_owner < 0) ? '0 : N'(1) << m_owner;
            check_out($sformatf("rnd%0d", c), e);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
